// File: rtl/route_collector.sv
// Merge end of the route distributor: 32 lane holding registers, round-robin
// serialization to one tagged stream, and pattern checking in forced modes.
module route_collector #(
  parameter int DATA_W = 32,
  parameter int LANES  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              mode_ctrl,
  input  logic [LANES-1:0]        lane_valid,
  input  logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [4:0]              out_tag,
  output logic                    pattern_err,
  output logic [4:0]              err_lane,
  output logic [15:0]             err_cnt
);

  localparam int M = DATA_W / 2;

  typedef enum logic [2:0] {
    NORMAL       = 3'b000,
    ALL_SET_0    = 3'b100,
    MIDDLE_SET_0 = 3'b101,
    MIDDLE_SET_1 = 3'b110,
    ALL_SET_1    = 3'b111
  } mode_t;

  mode_t             mode_d, mode_q;
  logic [LANES-1:0]  hold_full;
  logic [DATA_W-1:0] hold_data [LANES];
  logic [4:0]        ptr;
  logic              cand_any;
  logic [4:0]        cand_idx;
  logic [4:0]        probe;
  logic              test_mode;
  logic              grant;
  logic [DATA_W-1:0] mid_mask;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  always_comb begin
    case (mode_ctrl)
      3'b111:  mode_d = ALL_SET_1;
      3'b100:  mode_d = ALL_SET_0;
      3'b110:  mode_d = MIDDLE_SET_1;
      3'b101:  mode_d = MIDDLE_SET_0;
      default: mode_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= NORMAL;
    else     mode_q <= mode_d;
  end

  assign lane_ready = ~hold_full;

  // Search starts at ptr+1; the 5-bit sum wraps 31 -> 0 and k=32 lands on ptr.
  always_comb begin
    cand_any = 1'b0;
    cand_idx = '0;
    probe    = '0;
    for (int unsigned k = 1; k <= 32; k++) begin
      probe = ptr + 5'(k);
      if (!cand_any && hold_full[probe]) begin
        cand_any = 1'b1;
        cand_idx = probe;
      end
    end
  end

  assign test_mode = (mode_q != NORMAL);
  assign grant     = cand_any && (test_mode || !out_valid || out_ready);

  always_comb begin
    mid_mask          = '0;
    mid_mask[M]       = 1'b1;
    mid_mask[M-1]     = 1'b1;
    case (mode_q)
      ALL_SET_1:    expected = '1;
      MIDDLE_SET_1: expected = mid_mask;
      MIDDLE_SET_0: expected = ~mid_mask;
      default:      expected = '0;
    endcase
  end

  assign mismatch = grant && test_mode && (hold_data[cand_idx] != expected);

  // A granted lane is full, so it can never also be accepting in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= '0;
      for (int unsigned i = 0; i < LANES; i++) hold_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (grant && cand_idx == 5'(i)) begin
          hold_full[i] <= 1'b0;
        end else if (lane_valid[i] && !hold_full[i]) begin
          hold_full[i] <= 1'b1;
          hold_data[i] <= lane_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= 5'd31;
    else if (grant) ptr <= cand_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (grant && !test_mode) begin
      out_valid <= 1'b1;
      out_data  <= hold_data[cand_idx];
      out_tag   <= cand_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_err <= 1'b0;
      err_lane    <= '0;
      err_cnt     <= '0;
    end else begin
      pattern_err <= mismatch;
      if (mismatch) begin
        err_lane <= cand_idx;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_route_collector.sv
// Directed bench for route_collector: ordering, latency, back-pressure,
// pattern checking, counter saturation and asynchronous reset.
module tb_route_collector;

  localparam int DW = 32;
  localparam int NL = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     mode_ctrl;
  logic [NL-1:0]  lane_valid;
  logic [NL*DW-1:0] lane_data;
  logic [NL-1:0]  lane_ready;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [4:0]     out_tag;
  logic           pattern_err;
  logic [4:0]     err_lane;
  logic [15:0]    err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  route_collector #(.DATA_W(DW), .LANES(NL)) dut (
    .clk(clk), .rst(rst), .mode_ctrl(mode_ctrl),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .pattern_err(pattern_err), .err_lane(err_lane),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int lane, input logic [DW-1:0] d);
    lane_valid[lane] = 1'b1;
    lane_data[lane*DW +: DW] = d;
  endtask

  task automatic drain(input string name);
    int n;
    lane_valid = '0;
    out_ready  = 1'b1;
    n = 0;
    while (n < 200 && !(out_valid == 1'b0 && lane_ready == '1)) begin
      step(1);
      n++;
    end
    chk_cnt++;
    if (out_valid !== 1'b0 || lane_ready !== '1)
      $display("FAIL %s_drain: out_valid=%b lane_ready=%h, required 0 / ffffffff", name, out_valid, lane_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b0; mode_ctrl = 3'b000; lane_valid = '0; lane_data = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    step(2);
    chk_cnt++;
    if (lane_ready !== '1 || out_valid !== 1'b0 || out_data !== '0 || out_tag !== 5'd0)
      $display("FAIL reset_out: ready=%h valid=%b data=%h tag=%0d, required ffffffff 0 0 0", lane_ready, out_valid, out_data, out_tag);
    else pass_cnt++;
    chk_cnt++;
    if (pattern_err !== 1'b0 || err_lane !== 5'd0 || err_cnt !== 16'd0)
      $display("FAIL reset_err: perr=%b lane=%0d cnt=%0d, required 0 0 0", pattern_err, err_lane, err_cnt);
    else pass_cnt++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_order_latency;
    logic [4:0]    tags [3];
    logic [DW-1:0] dats [3];
    tags = '{5'd0, 5'd5, 5'd31};
    dats = '{32'hA0, 32'hA5, 32'hBF};
    put(0, 32'hA0); put(5, 32'hA5); put(31, 32'hBF);
    step(1);
    lane_valid = '0;
    chk_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL order_early: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_tag !== tags[k] || out_data !== dats[k])
        $display("FAIL order_%0d: valid=%b tag=%0d data=%h, required 1 %0d %h", k, out_valid, out_tag, out_data, tags[k], dats[k]);
      else pass_cnt++;
    end
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL order_end: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < NL; i++) put(i, 32'hC00 + DW'(i));
    step(1);
    for (int k = 0; k < 40; k++) begin
      step(1);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_tag !== 5'(k % 32) || out_data !== 32'hC00 + DW'(k % 32))
        $display("FAIL rr_%0d: valid=%b tag=%0d data=%h, required 1 %0d %h", k, out_valid, out_tag, out_data, k % 32, 32'hC00 + DW'(k % 32));
      else pass_cnt++;
    end
    drain("rr");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    put(3, 32'h1234);
    step(1);
    lane_valid = '0;
    step(1);
    chk_cnt++;
    if (lane_ready[3] !== 1'b1)
      $display("FAIL bp_ready_back: lane_ready[3]=%b, required 1", lane_ready[3]);
    else pass_cnt++;
    put(3, 32'h5678);
    for (int k = 0; k < 5; k++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_tag !== 5'd3)
        $display("FAIL bp_hold_%0d: valid=%b data=%h tag=%0d, required 1 00001234 3", k, out_valid, out_data, out_tag);
      else pass_cnt++;
      step(1);
      lane_valid = '0;
    end
    chk_cnt++;
    if (lane_ready[3] !== 1'b0)
      $display("FAIL bp_second_held: lane_ready[3]=%b, required 0", lane_ready[3]);
    else pass_cnt++;
    out_ready = 1'b1;
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h5678 || out_tag !== 5'd3)
      $display("FAIL bp_second: valid=%b data=%h tag=%0d, required 1 00005678 3", out_valid, out_data, out_tag);
    else pass_cnt++;
    drain("bp");
  endtask

  task automatic test_middle_set_1;
    mode_ctrl = 3'b110;
    step(2);
    put(7, 32'h00018000);
    step(1);
    lane_valid = '0;
    step(1);
    chk_cnt++;
    if (pattern_err !== 1'b0 || out_valid !== 1'b0 || err_cnt !== 16'd0)
      $display("FAIL mid_match: perr=%b valid=%b cnt=%0d, required 0 0 0", pattern_err, out_valid, err_cnt);
    else pass_cnt++;
    put(7, 32'h00008000);
    step(1);
    lane_valid = '0;
    step(1);
    chk_cnt++;
    if (pattern_err !== 1'b1 || err_lane !== 5'd7 || err_cnt !== 16'd1 || out_valid !== 1'b0)
      $display("FAIL mid_mismatch: perr=%b lane=%0d cnt=%0d valid=%b, required 1 7 1 0", pattern_err, err_lane, err_cnt, out_valid);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (pattern_err !== 1'b0 || err_cnt !== 16'd1)
      $display("FAIL mid_pulse: perr=%b cnt=%0d, required 0 1", pattern_err, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    mode_ctrl = 3'b100;
    step(2);
    for (int i = 0; i < NL; i++) put(i, 32'h100 + DW'(i));
    step(65600);
    chk_cnt++;
    if (err_cnt !== 16'hFFFF || pattern_err !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL sat_reach: cnt=%h perr=%b valid=%b, required ffff 1 0", err_cnt, pattern_err, out_valid);
    else pass_cnt++;
    step(50);
    chk_cnt++;
    if (err_cnt !== 16'hFFFF)
      $display("FAIL sat_hold: cnt=%h, required ffff", err_cnt);
    else pass_cnt++;
    drain("sat");
    mode_ctrl = 3'b000;
    step(2);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) put(i, 32'hD0 + DW'(i));
    step(1);
    lane_valid = '0;
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b1 || $countones(~lane_ready) != 10)
      $display("FAIL rstmid_pre: valid=%b full=%0d, required 1 10", out_valid, $countones(~lane_ready));
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || lane_ready !== '1 || err_cnt !== 16'd0 || pattern_err !== 1'b0)
      $display("FAIL rstmid_async: valid=%b ready=%h cnt=%h perr=%b, required 0 ffffffff 0 0", out_valid, lane_ready, err_cnt, pattern_err);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    put(31, 32'hE31); put(0, 32'hE00);
    step(1);
    lane_valid = '0;
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_tag !== 5'd0 || out_data !== 32'hE00)
      $display("FAIL rstmid_first: valid=%b tag=%0d data=%h, required 1 0 00000e00", out_valid, out_tag, out_data);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_tag !== 5'd31 || out_data !== 32'hE31)
      $display("FAIL rstmid_second: valid=%b tag=%0d data=%h, required 1 31 00000e31", out_valid, out_tag, out_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_order_latency();
    test_round_robin();
    test_backpressure();
    test_middle_set_1();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/route_collector.md
# route_collector

Merge block at the far end of the route distributor: gathers words arriving on 32 destination lanes and serializes them into one tagged output stream. A round-robin arbiter picks among per-lane holding registers, and each word is tagged with the 5-bit lane code OUT1..OUT32 (5'b00000..5'b11111). In the distributor's forced modes (ALL_SET_1, ALL_SET_0, MIDDLE_SET_1, MIDDLE_SET_0), the block checks the received lane words against the expected pattern and counts mismatches instead of forwarding them.

## Interface
- DATA_W, 32, lane and output word width; even, at least 4
- LANES, 32, number of input lanes; fixed at 32 to match the 5-bit tag
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- mode_ctrl  input  3  mode_ctrl_t code: NORMAL=000, ALL_SET_1=111, ALL_SET_0=100, MIDDLE_SET_1=110, MIDDLE_SET_0=101
- lane_valid  input  LANES  per-lane word valid
- lane_data  input  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- lane_ready  output  LANES  per-lane accept
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  output word
- out_tag  output  5  source lane code; lane i gives tag i (OUT(i+1))
- pattern_err  output  1  one-cycle pulse on a pattern mismatch
- err_lane  output  5  lane code of the most recent mismatch
- err_cnt  output  16  saturating mismatch count

## Operation
- Mode register:
  - mode_ctrl is registered every cycle into mode_q.
  - Codes 001, 010 and 011 decode as NORMAL.
- Per-lane holding register (one entry per lane):
  - lane_ready[i] = !hold_full[i], driven from state only.
  - A lane accepts a word in any cycle where lane_valid[i] & lane_ready[i].
  - A lane's full flag clears when that lane is granted.
- Arbiter:
  - Candidates are all lanes with hold_full set.
  - Priority starts at ptr+1 and wraps from 31 to 0.
  - On a grant, ptr takes the granted index.
  - Reset value of ptr is 31, so lane 0 has priority first.
- NORMAL mode:
  - A grant is issued only when the output register is empty, or when it is draining this cycle (out_valid & out_ready).
  - The granted word and its tag load into the output register.
  - out_data and out_tag stay stable while out_valid & !out_ready.
- Test modes (mode_q not NORMAL):
  - A grant is issued every cycle that a candidate exists, regardless of output state.
  - The word is compared and discarded; the output register is not loaded.
  - A word already in the output register still drains normally.
- Expected patterns, with M = DATA_W/2:
  - ALL_SET_1: all ones.
  - ALL_SET_0: all zeros.
  - MIDDLE_SET_1: bits M and M-1 are 1, all other bits 0.
  - MIDDLE_SET_0: bits M and M-1 are 0, all other bits 1.
- On a mismatch:
  - pattern_err pulses for one cycle.
  - err_lane takes the granted lane code.
  - err_cnt increments and saturates at 16'hFFFF.
- A mode change takes effect on grants from the cycle after it is registered. Held words are never dropped.
- Simultaneous events:
  - A lane that is granted in a cycle does not accept a new word in that same cycle, because lane_ready reflects hold_full of that cycle.
  - Accepting and draining on one lane takes two cycles.

## Timing
- Reset values:
  - lane_ready all 1
  - out_valid 0, out_data 0, out_tag 0
  - pattern_err 0, err_lane 0, err_cnt 0
  - all hold_full 0, ptr 31, mode_q NORMAL
- NORMAL latency:
  - A word is accepted on lane i in cycle N.
  - hold_full is set in cycle N+1, and the lane is granted in N+1 if it wins arbitration.
  - out_valid is high in cycle N+2.
- Throughput:
  - Aggregate: one word per cycle with out_ready held high.
  - Per lane: at most one word every 2 cycles.
- Test-mode check:
  - A word accepted in cycle N is compared on its grant in cycle N+1.
  - pattern_err, err_lane and err_cnt update and are visible in cycle N+2.
- Reset mid-operation:
  - All held and output words are dropped immediately (asynchronous).
  - Outputs return to their reset values in the same cycle that rst is asserted.

## Test plan
- Out of reset, NORMAL mode, lanes 0, 5 and 31 present 32'hA0, 32'hA5 and 32'hBF in the same cycle, out_ready=1 -> words come out in consecutive cycles with tags 0, 5, 31. First out_valid is 2 cycles after acceptance.
- All 32 lanes full, out_ready=1 -> tags 0, 1, ..., 31, then wrap back to 0 on the refill. No lane is granted twice before every other full lane has been granted.
- Lane 3 sends 32'h1234, out_ready=0 for 5 cycles -> out_valid, out_data=32'h1234 and out_tag=3 stay stable for all 5 cycles. lane_ready[3] returns to 1 after the grant. A second word on lane 3 is held.
- mode_ctrl=MIDDLE_SET_1, DATA_W=32, lane 7 sends 32'h00018000 then 32'h00008000 -> out_valid stays 0. One pattern_err pulse for the second word, err_lane=7, err_cnt=1.
- mode_ctrl=ALL_SET_0, 70000 mismatching words -> err_cnt saturates at 16'hFFFF and does not wrap.
- Assert rst with 10 lanes full and out_valid=1 -> in the same cycle out_valid=0, all lane_ready=1 and err_cnt=0. The next grant after release goes to lane 0.
